mp_add_sequencer: RTL and testbench

- Multi-precision add/subtract controller that time-multiplexes a single 8-bit adder slice (a + b + cin -> sum, cout) across WORDS byte lanes.
- Carry is chained between bytes through a register.
- Sits between an operand producer and a result consumer, with valid/ready handshakes on both sides.
- One operation is in flight at a time. The block sequences the narrow adder so that wide arithmetic costs one adder plus WORDS cycles.

---
 rtl/mp_add_sequencer_if.sv | 28 ++
 rtl/mp_add_sequencer.sv | 130 +++++++++++++
 tb/tb_mp_add_sequencer.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mp_add_sequencer_if.sv
// Operand/result handshake bundle for mp_add_sequencer.
// The producer and consumer sides share one interface so the bench can drive both.
interface mp_add_sequencer_if #(
   parameter int WORDS = 4
);
   localparam int W = 8 * WORDS;

   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] op_a;
   logic [W-1:0] op_b;
   logic         sub;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] result;
   logic         carry_out;
   logic         overflow;

   modport master (
      output in_valid, op_a, op_b, sub, out_ready,
      input  in_ready, out_valid, result, carry_out, overflow
   );

   modport slave (
      input  in_valid, op_a, op_b, sub, out_ready,
      output in_ready, out_valid, result, carry_out, overflow
   );
endinterface

// File: rtl/mp_add_sequencer.sv
// Multi-precision add/subtract: one 8-bit adder slice reused across WORDS byte lanes,
// carry chained through a register, one operation in flight at a time.
module mp_add_sequencer #(
   parameter int WORDS = 4
) (
   input  logic                clk,
   input  logic                rst,
   mp_add_sequencer_if.slave   bus,
   output logic                busy
);
   localparam int W  = 8 * WORDS;
   localparam int IW = $clog2(WORDS);
   localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_e;

   state_e        state_q, state_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [W-1:0]  a_q, a_d;
   logic [W-1:0]  b_q, b_d;
   logic          carry_q, carry_d;
   logic [W-1:0]  result_q, result_d;
   logic          carry_out_q, carry_out_d;
   logic          overflow_q, overflow_d;
   logic          in_ready_q, in_ready_d;
   logic          out_valid_q, out_valid_d;
   logic          busy_q, busy_d;

   logic [7:0]    a_byte_s;
   logic [7:0]    b_byte_s;
   logic [8:0]    slice_s;

   // Shared byte-wide adder operating on the lane selected by idx.
   always_comb begin
      a_byte_s = a_q[8*idx_q +: 8];
      b_byte_s = b_q[8*idx_q +: 8];
      slice_s  = {1'b0, a_byte_s} + {1'b0, b_byte_s} + {8'd0, carry_q};
   end

   // Next-state, datapath updates and registered-output decode.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      a_d         = a_q;
      b_d         = b_q;
      carry_d     = carry_q;
      result_d    = result_q;
      carry_out_d = carry_out_q;
      overflow_d  = overflow_q;
      case (state_q)
         S_IDLE: begin
            if (bus.in_valid) begin
               // Subtract is A + ~B + 1: the +1 enters as the initial carry.
               a_d     = bus.op_a;
               b_d     = bus.sub ? ~bus.op_b : bus.op_b;
               carry_d = bus.sub;
               idx_d   = '0;
               state_d = S_RUN;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_RUN: begin
            result_d[8*idx_q +: 8] = slice_s[7:0];
            carry_d                = slice_s[8];
            if (idx_q == LAST_IDX) begin
               carry_out_d = slice_s[8];
               overflow_d  = (a_q[W-1] == b_q[W-1]) && (slice_s[7] != a_q[W-1]);
               idx_d       = '0;
               state_d     = S_DONE;
            end else begin
               idx_d       = idx_q + IW'(1);
            end
         end
         S_DONE: begin
            if (bus.out_ready) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_DONE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      in_ready_d  = (state_d == S_IDLE);
      out_valid_d = (state_d == S_DONE);
      busy_d      = (state_d != S_IDLE);
   end

   // State and datapath registers; reset dominates everything.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         idx_q       <= '0;
         a_q         <= '0;
         b_q         <= '0;
         carry_q     <= 1'b0;
         result_q    <= '0;
         carry_out_q <= 1'b0;
         overflow_q  <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         a_q         <= a_d;
         b_q         <= b_d;
         carry_q     <= carry_d;
         result_q    <= result_d;
         carry_out_q <= carry_out_d;
         overflow_q  <= overflow_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.result    = result_q;
   assign bus.carry_out = carry_out_q;
   assign bus.overflow  = overflow_q;
   assign busy          = busy_q;
endmodule

// File: tb/tb_mp_add_sequencer.sv
// Self-checking bench for mp_add_sequencer: directed vectors with literal expectations,
// plus a W-bit arithmetic reference model checked on every cycle out_valid is high.
module tb_mp_add_sequencer;
   localparam int WORDS = 4;
   localparam int W     = 8 * WORDS;
   localparam longint MAXS = (longint'(1) << (W - 1)) - 1;
   localparam longint MINS = -(longint'(1) << (W - 1));

   typedef struct packed {
      logic         ovf;
      logic         c;
      logic [W-1:0] r;
   } exp_t;

   logic clk;
   logic rst;
   logic busy;
   int   errors = 0;
   int   checks = 0;
   int   cyc    = 0;
   int   last_acc = 0;
   int   prev_acc = -1;
   bit   b2b    = 1'b0;
   bit   ov_prev = 1'b0;
   exp_t exp_q[$];

   mp_add_sequencer_if #(.WORDS(WORDS)) bus ();

   mp_add_sequencer #(.WORDS(WORDS)) dut (
      .clk  (clk),
      .rst  (rst),
      .bus  (bus),
      .busy (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: plain unsigned/signed integer arithmetic on the full width.
   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
      exp_t         e;
      longint       sa;
      longint       sb;
      longint       sd;
      logic [W:0]   wide;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (s) begin
         e.r = a - b;
         e.c = (a >= b);
         sd  = sa - sb;
      end else begin
         wide = {1'b0, a} + {1'b0, b};
         e.r  = wide[W-1:0];
         e.c  = wide[W];
         sd   = sa + sb;
      end
      e.ovf = (sd > MAXS) || (sd < MINS);
      return e;
   endfunction

   // Monitor/compare: records accepts, checks every valid-result cycle against the model.
   always @(negedge clk) begin
      if (bus.out_valid) begin
         if (exp_q.size() == 0) begin
            chk("spurious_out_valid", 64'd1, 64'd0);
         end else begin
            chk("model_result", bus.result, exp_q[0].r);
            chk("model_carry", bus.carry_out, exp_q[0].c);
            chk("model_overflow", bus.overflow, exp_q[0].ovf);
         end
         chk("in_ready_in_done", bus.in_ready, 1'b0);
         if (!ov_prev) chk("latency", cyc - last_acc, WORDS);
         if (bus.out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
      end
      ov_prev = bus.out_valid;
      if (rst) begin
         exp_q.delete();
         prev_acc = -1;
      end else if (bus.in_valid && bus.in_ready) begin
         exp_q.push_back(model(bus.op_a, bus.op_b, bus.sub));
         if (b2b && prev_acc >= 0) chk("issue_interval", (cyc + 1) - prev_acc, WORDS + 2);
         prev_acc = cyc + 1;
         last_acc = cyc + 1;
      end
   end

   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
      int n = 0;
      bus.in_valid = 1'b1;
      bus.op_a     = a;
      bus.op_b     = b;
      bus.sub      = s;
      while (!bus.in_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (!bus.in_ready) chk("accept_timeout", 64'd0, 64'd1);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_valid();
      int n = 0;
      while (!bus.out_valid && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (!bus.out_valid) chk("out_valid_timeout", 64'd0, 64'd1);
   endtask

   task automatic directed(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic s, input logic [W-1:0] er, input logic ec, input logic ev);
      issue(a, b, s);
      chk({nm, "_busy_run"}, busy, 1'b1);
      chk({nm, "_in_ready_run"}, bus.in_ready, 1'b0);
      wait_valid();
      chk({nm, "_result"}, bus.result, er);
      chk({nm, "_carry"}, bus.carry_out, ec);
      chk({nm, "_overflow"}, bus.overflow, ev);
      @(posedge clk); #1;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      chk({nm, "_out_valid_drop"}, bus.out_valid, 1'b0);
      chk({nm, "_in_ready_back"}, bus.in_ready, 1'b1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      clk = 1'b0;
      rst = 1'b1;
      bus.in_valid  = 1'b0;
      bus.op_a      = '0;
      bus.op_b      = '0;
      bus.sub       = 1'b0;
      bus.out_ready = 1'b0;

      // Pin the reference model to hand-computed values.
      chk("pin_add_wrap", model(32'hFFFF_FFFF, 32'h0000_0001, 1'b0), {1'b0, 1'b1, 32'h0000_0000});
      chk("pin_add_ovf",  model(32'h7FFF_FFFF, 32'h0000_0001, 1'b0), {1'b1, 1'b0, 32'h8000_0000});
      chk("pin_add_plain", model(32'h1234_5678, 32'h1111_1111, 1'b0), {1'b0, 1'b0, 32'h2345_6789});
      chk("pin_sub_borrow", model(32'h0000_0005, 32'h0000_0007, 1'b1), {1'b0, 1'b0, 32'hFFFF_FFFE});
      chk("pin_sub_ovf",  model(32'h8000_0000, 32'h0000_0001, 1'b1), {1'b1, 1'b1, 32'h7FFF_FFFF});

      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", bus.in_ready, 1'b1);
      chk("rst_out_valid", bus.out_valid, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_result", bus.result, 32'h0);
      chk("rst_carry", bus.carry_out, 1'b0);
      chk("rst_overflow", bus.overflow, 1'b0);
      rst = 1'b0;
      @(posedge clk); #1;

      directed("add_wrap",  32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
      directed("add_ovf",   32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
      directed("add_plain", 32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0);
      directed("sub_borrow", 32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
      directed("sub_ovf",   32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);

      // Backpressure: hold the consumer off while a second request knocks.
      issue(32'h0000_00F0, 32'h0000_0F0F, 1'b0);
      wait_valid();
      bus.in_valid = 1'b1;
      bus.op_a     = 32'hDEAD_BEEF;
      bus.op_b     = 32'h0BAD_F00D;
      bus.sub      = 1'b1;
      for (int i = 0; i < 10; i++) begin
         chk("bp_out_valid", bus.out_valid, 1'b1);
         chk("bp_in_ready", bus.in_ready, 1'b0);
         chk("bp_result", bus.result, 32'h0000_0FFF);
         chk("bp_flags", {bus.carry_out, bus.overflow}, 2'b00);
         @(posedge clk); #1;
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      chk("bp_release_in_ready", bus.in_ready, 1'b1);
      chk("bp_release_out_valid", bus.out_valid, 1'b0);
      chk("bp_second_ignored", exp_q.size(), 0);

      // Reset during the second RUN cycle aborts the operation.
      issue(32'hAAAA_AAAA, 32'h5555_5555, 1'b0);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("abort_in_ready", bus.in_ready, 1'b1);
      chk("abort_busy", busy, 1'b0);
      chk("abort_result", bus.result, 32'h0);
      chk("abort_flags", {bus.carry_out, bus.overflow}, 2'b00);
      for (int i = 0; i < 6; i++) begin
         chk("abort_no_out_valid", bus.out_valid, 1'b0);
         @(posedge clk); #1;
      end
      directed("after_abort", 32'h0000_0001, 32'h0000_0001, 1'b0, 32'h0000_0002, 1'b0, 1'b0);

      // Back-to-back random traffic with both handshakes held high.
      prev_acc = -1;
      b2b = 1'b1;
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      for (int i = 0; i < 100; i++) begin
         bus.op_a = W'($urandom);
         bus.op_b = W'($urandom);
         bus.sub  = 1'($urandom_range(0, 1));
         n = 0;
         while (!bus.in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
         end
         if (!bus.in_ready) chk("b2b_accept_timeout", 64'd0, 64'd1);
         @(posedge clk); #1;
      end
      bus.in_valid = 1'b0;
      wait_valid();
      repeat (4) @(posedge clk);
      #1;
      chk("b2b_drained", exp_q.size(), 0);
      chk("b2b_idle", busy, 1'b0);
      b2b = 1'b0;
      bus.out_ready = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
